nfc_data_out_atom: RTL and testbench

NFC_DATA_OUT_ATOM -- requirements
Module: nfc_data_out_atom

---
 rtl/nfc_data_out_atom_if.sv | 33 +++
 rtl/nfc_data_out_atom.sv | 118 +++++++++++
 tb/tb_nfc_data_out_atom.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nfc_data_out_atom_if.sv
// Signal bundle between the NAND write-data sequencer, its data source and the DQ/DQS PHY.
// The master side drives the requests and write data; the slave side is nfc_data_out_atom.
interface nfc_data_out_atom_if #(
    parameter int NumberOfWays = 4
);
    logic                    iStart;
    logic                    oReady;
    logic                    oLastStep;
    logic [NumberOfWays-1:0] iTargetWay;
    logic [15:0]             iNumOfData;
    logic [15:0]             iWriteData;
    logic                    iWriteLast;
    logic                    iWriteValid;
    logic                    oWriteReady;
    logic [15:0]             oPO_DQ;
    logic                    oPO_DQValid;
    logic                    oPO_DQOutEnable;
    logic                    oPO_DQSToggle;
    logic [NumberOfWays-1:0] oPO_ChipEnable;
    logic                    oLengthError;

    modport master (
        output iStart, iTargetWay, iNumOfData, iWriteData, iWriteLast, iWriteValid,
        input  oReady, oLastStep, oWriteReady, oPO_DQ, oPO_DQValid, oPO_DQOutEnable,
               oPO_DQSToggle, oPO_ChipEnable, oLengthError
    );

    modport slave (
        input  iStart, iTargetWay, iNumOfData, iWriteData, iWriteLast, iWriteValid,
        output oReady, oLastStep, oWriteReady, oPO_DQ, oPO_DQValid, oPO_DQOutEnable,
               oPO_DQSToggle, oPO_ChipEnable, oLengthError
    );
endinterface

// File: rtl/nfc_data_out_atom.sv
// NAND DDR write-data sequencer: DQS preamble, byte-pair data burst, postamble, completion pulse.
// Define NFC_DOA_LENGTH_CHECK_EN to enable the sticky iWriteLast length-mismatch flag.
module nfc_data_out_atom #(
    parameter int NumberOfWays    = 4,
    parameter int PreambleCycles  = 2,
    parameter int PostambleCycles = 2
) (
    input  logic               iSystemClock,
    input  logic               iReset,
    nfc_data_out_atom_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, POSTAMBLE, DONE} state_t;

    localparam logic [15:0] PreLast  = 16'(PreambleCycles - 1);
    localparam logic [15:0] PostLast = 16'(PostambleCycles - 1);

    state_t                  state;
    state_t                  nextState;
    logic [15:0]             phaseCount;
    logic [16:0]             wordsLeft;
    logic [16:0]             startWords;
    logic [NumberOfWays-1:0] wayReg;
    logic                    oddLen;
    logic [15:0]             dq_p1;
    logic                    vld_p1;
    logic                    busy;
    logic                    accept;
    logic                    writeReady;
    logic                    xfer;
    logic                    lastWord;

    // An odd byte count leaves the final word's lower byte undefined, so it is forced to zero.
    function automatic logic [15:0] padFinalWord(input logic [15:0] word, input logic padLow);
        return padLow ? {word[15:8], 8'h00} : word;
    endfunction

    assign startWords = ({1'b0, bus.iNumOfData} + 17'd1) >> 1;
    assign busy       = (state == PREAMBLE) || (state == DATA) || (state == POSTAMBLE);
    assign accept     = (state == IDLE) && bus.iStart;
    assign writeReady = (state == DATA) && (wordsLeft != 17'd0);
    assign xfer       = writeReady && bus.iWriteValid;
    assign lastWord   = (wordsLeft == 17'd1);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (bus.iStart) nextState = (startWords == 17'd0) ? DONE : PREAMBLE;
            PREAMBLE:  if (phaseCount == PreLast) nextState = DATA;
            DATA:      if (xfer && lastWord) nextState = POSTAMBLE;
            POSTAMBLE: if (phaseCount == PostLast) nextState = DONE;
            DONE:      nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            state      <= IDLE;
            phaseCount <= 16'd0;
            wordsLeft  <= 17'd0;
        end else begin
            state      <= nextState;
            phaseCount <= ((state == PREAMBLE || state == POSTAMBLE) && nextState == state)
                          ? phaseCount + 16'd1 : 16'd0;
            if (accept)
                wordsLeft <= startWords;
            else if (xfer)
                wordsLeft <= wordsLeft - 17'd1;
        end
    end

    always_ff @(posedge iSystemClock) begin
        if (accept) begin
            wayReg <= bus.iTargetWay;
            oddLen <= bus.iNumOfData[0];
        end
    end

    // Stage p1: accepted word registered toward the PHY; DQS toggles only with a fresh word.
    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            dq_p1  <= 16'd0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= xfer;
            if (xfer)
                dq_p1 <= padFinalWord(bus.iWriteData, oddLen && lastWord);
        end
    end

`ifdef NFC_DOA_LENGTH_CHECK_EN
    logic lengthError;

    // Flags a last marker on the wrong word or missing on the final one; never alters sequencing.
    always_ff @(posedge iSystemClock) begin
        if (iReset || accept)
            lengthError <= 1'b0;
        else if (xfer && (bus.iWriteLast != lastWord))
            lengthError <= 1'b1;
    end

    assign bus.oLengthError = lengthError;
`else
    logic unusedWriteLast;

    assign unusedWriteLast  = bus.iWriteLast;
    assign bus.oLengthError = 1'b0;
`endif

    assign bus.oReady          = (state == IDLE);
    assign bus.oLastStep       = (state == DONE);
    assign bus.oWriteReady     = writeReady;
    assign bus.oPO_DQ          = dq_p1;
    assign bus.oPO_DQValid     = vld_p1;
    assign bus.oPO_DQSToggle   = vld_p1;
    assign bus.oPO_DQOutEnable = busy;
    assign bus.oPO_ChipEnable  = busy ? wayReg : {NumberOfWays{1'b1}};
endmodule

// File: tb/tb_nfc_data_out_atom.sv
// Randomized bench for nfc_data_out_atom against a transaction-timeline reference model.
module tb_nfc_data_out_atom;
    localparam int Ways   = 4;
    localparam int Pre    = 2;
    localparam int Post   = 2;
    localparam int MaxOff = 400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nfc_data_out_atom_if #(.NumberOfWays(Ways)) bus();

    nfc_data_out_atom #(
        .NumberOfWays(Ways), .PreambleCycles(Pre), .PostambleCycles(Post)
    ) dut (
        .iSystemClock(clk),
        .iReset(rst),
        .bus(bus)
    );

    int nVec = 0;
    int nMis = 0;

    // expected outputs for the current cycle
    logic            expOn = 1'b0;
    logic            eReady, eLast, eWR, eVld, eOE, eLen;
    logic [15:0]     eDq;
    logic [Ways-1:0] eCE;

    // model carry between transactions
    logic [15:0] lastDq = 16'h0;
    logic        lenErrCarry = 1'b0;

    // observations of the DUT for literal pins
    int          curOff;
    int          obsLastOff;
    int          obsTog;
    int          obsBusyCyc;
    logic [15:0] obsDq[$];

    logic [15:0] words[MaxOff];
    int          xferAt[MaxOff];
    bit          dValid[MaxOff];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (expOn) begin
            check("oReady",          32'(bus.oReady),          32'(eReady));
            check("oLastStep",       32'(bus.oLastStep),       32'(eLast));
            check("oWriteReady",     32'(bus.oWriteReady),     32'(eWR));
            check("oPO_DQValid",     32'(bus.oPO_DQValid),     32'(eVld));
            check("oPO_DQSToggle",   32'(bus.oPO_DQSToggle),   32'(eVld));
            check("oPO_DQ",          32'(bus.oPO_DQ),          32'(eDq));
            check("oPO_DQOutEnable", 32'(bus.oPO_DQOutEnable), 32'(eOE));
            check("oPO_ChipEnable",  32'(bus.oPO_ChipEnable),  32'(eCE));
            check("oLengthError",    32'(bus.oLengthError),    32'(eLen));
            if (bus.oLastStep === 1'b1) obsLastOff = curOff;
            if (bus.oPO_DQSToggle === 1'b1) begin
                obsTog++;
                obsDq.push_back(bus.oPO_DQ);
            end
            if (bus.oPO_DQOutEnable !== 1'b0 || bus.oPO_ChipEnable !== {Ways{1'b1}}) obsBusyCyc++;
        end
    end

    task automatic setIdleExpect();
        eReady = 1'b1; eLast = 1'b0; eWR = 1'b0; eVld = 1'b0;
        eOE = 1'b0; eCE = {Ways{1'b1}}; eDq = lastDq;
`ifdef NFC_DOA_LENGTH_CHECK_EN
        eLen = lenErrCarry;
`else
        eLen = 1'b0;
`endif
    endtask

    task automatic idleCycle();
        rst             = 1'b0;
        bus.iStart      = 1'b0;
        bus.iTargetWay  = Ways'($urandom);
        bus.iNumOfData  = 16'($urandom);
        bus.iWriteData  = 16'($urandom);
        bus.iWriteLast  = 1'($urandom);
        bus.iWriteValid = 1'($urandom);
        setIdleExpect();
        expOn = 1'b1;
        @(posedge clk); #1;
    endtask

    // stallMode: 0 valid held high, 1 random valid, 2 five-cycle stall after the first word
    task automatic runTxn(input int nBytes, input logic [Ways-1:0] way, input int stallMode,
                          input int errWord, input int resetAt, input bit useFixed,
                          input logic [15:0] fw0, input logic [15:0] fw1);
        int w, k, kb, lastX, doneOff;
        logic [15:0] pw;
        w = (nBytes + 1) >> 1;
        for (int i = 0; i < MaxOff; i++) begin
            if (stallMode == 1) dValid[i] = (i > 150) ? 1'b1 : ($urandom_range(0, 3) != 0);
            else                dValid[i] = 1'b1;
        end
        if (stallMode == 2)
            for (int i = Pre + 2; i <= Pre + 6; i++) dValid[i] = 1'b0;
        for (int i = 0; i < w; i++) words[i] = 16'($urandom);
        if (useFixed) begin
            words[0] = fw0;
            words[1] = fw1;
        end
        k = 0;
        for (int t = Pre + 1; k < w; t++)
            if (dValid[t]) begin
                xferAt[k] = t;
                k++;
            end
        lastX   = (w > 0) ? xferAt[w-1] : 0;
        doneOff = (w > 0) ? lastX + Post + 1 : 1;

        obsLastOff = -1; obsTog = 0; obsBusyCyc = 0;
        obsDq.delete();
        kb = 0;
        for (int t = 0; t <= doneOff; t++) begin
            rst             = (t == resetAt);
            bus.iStart      = (t == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
            bus.iTargetWay  = (t == 0) ? way : Ways'($urandom);
            bus.iNumOfData  = (t == 0) ? 16'(nBytes) : 16'($urandom);
            bus.iWriteValid = dValid[t];
            bus.iWriteData  = (kb < w) ? words[kb] : 16'($urandom);
            bus.iWriteLast  = (kb < w) ? ((kb == w - 1) != (kb == errWord)) : 1'($urandom);

            curOff = t;
            eReady = (t == 0);
            eLast  = (t == doneOff);
            eWR    = (w > 0) && (t >= Pre + 1) && (t <= lastX);
            eOE    = (w > 0) && (t >= 1) && (t <= lastX + Post);
            eCE    = eOE ? way : {Ways{1'b1}};
            eVld   = (t >= 1) && (kb > 0) && (xferAt[kb-1] == t - 1);
            if (t == 1) lenErrCarry = 1'b0;
            if (eVld) begin
                pw = words[kb-1];
                if ((kb - 1 == w - 1) && (nBytes % 2 == 1)) pw[7:0] = 8'h00;
                lastDq = pw;
                if (kb - 1 == errWord) lenErrCarry = 1'b1;
            end
            eDq = lastDq;
`ifdef NFC_DOA_LENGTH_CHECK_EN
            eLen = lenErrCarry;
`else
            eLen = 1'b0;
`endif
            if (kb < w && xferAt[kb] == t) kb++;
            expOn = 1'b1;
            @(posedge clk); #1;
            if (t == resetAt) begin
                rst = 1'b0;
                lastDq = 16'h0;
                lenErrCarry = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.iStart = 1'b0; bus.iTargetWay = '1; bus.iNumOfData = 16'h0;
        bus.iWriteData = 16'h0; bus.iWriteLast = 1'b0; bus.iWriteValid = 1'b0;
        @(posedge clk); #1;
        setIdleExpect();
        expOn = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idleCycle();
        idleCycle();

        // four bytes, valid held high, back-to-back with the next transfer
        runTxn(4, 4'b1110, 0, -1, -1, 1'b1, 16'h1400, 16'h0000);
        check("lat_4B", 32'(obsLastOff), 32'd7);
        check("tog_4B", 32'(obsTog), 32'd2);
        if (obsDq.size() >= 2) begin
            check("dq0_4B", 32'(obsDq[0]), 32'h1400);
            check("dq1_4B", 32'(obsDq[1]), 32'h0000);
        end

        // odd byte count pads the last lower byte
        runTxn(3, 4'b1101, 0, -1, -1, 1'b1, 16'hABCD, 16'hEF12);
        check("tog_3B", 32'(obsTog), 32'd2);
        if (obsDq.size() >= 2) begin
            check("dq0_3B", 32'(obsDq[0]), 32'hABCD);
            check("dq1_3B", 32'(obsDq[1]), 32'hEF00);
        end
        idleCycle();

        // zero length goes straight to completion
        runTxn(0, 4'b0000, 0, -1, -1, 1'b0, 16'h0, 16'h0);
        check("lat_0B", 32'(obsLastOff), 32'd1);
        check("tog_0B", 32'(obsTog), 32'd0);
        check("busy_0B", 32'(obsBusyCyc), 32'd0);
        idleCycle();

        // stall between first and second word
        runTxn(6, 4'b1011, 2, -1, -1, 1'b0, 16'h0, 16'h0);
        check("tog_6B", 32'(obsTog), 32'd3);
        check("lat_6B", 32'(obsLastOff), 32'd13);
        idleCycle();

        // reset right after the first of four words
        runTxn(8, 4'b0111, 0, -1, Pre + 2, 1'b0, 16'h0, 16'h0);
        check("rst_dq",    32'(bus.oPO_DQ), 32'h0);
        check("rst_ready", 32'(bus.oReady), 32'd1);
        check("rst_ce",    32'(bus.oPO_ChipEnable), 32'hF);
        check("rst_wr",    32'(bus.oWriteReady), 32'd0);
        idleCycle();
        runTxn(8, 4'b0111, 0, -1, -1, 1'b0, 16'h0, 16'h0);
        check("lat_8B", 32'(obsLastOff), 32'd9);
        check("tog_8B", 32'(obsTog), 32'd4);
        idleCycle();

        // last marker on the first of two words
        runTxn(4, 4'b1110, 0, 0, -1, 1'b0, 16'h0, 16'h0);
        check("lat_lenerr", 32'(obsLastOff), 32'd7);
        idleCycle();
        idleCycle();
`ifdef NFC_DOA_LENGTH_CHECK_EN
        check("lenerr_sticky", 32'(bus.oLengthError), 32'd1);
`else
        check("lenerr_tied", 32'(bus.oLengthError), 32'd0);
`endif

        for (int n = 0; n < 40; n++) begin
            int nb, ew, wds, gap;
            nb  = int'($urandom_range(0, 24));
            wds = (nb + 1) >> 1;
            ew  = (wds > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, wds - 1)) : -1;
            runTxn(nb, Ways'($urandom), 1, ew, -1, 1'b0, 16'h0, 16'h0);
            gap = int'($urandom_range(0, 2));
            repeat (gap) idleCycle();
        end
        idleCycle();

        expOn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
